bcd_convert_scheduler: RTL and testbench
========================================

// Module: bcd_convert_scheduler
// PURPOSE
//   Shares one iterative binary-to-BCD engine (shift and add-3, one bit per clock) among NUM_REQ
//   requesters. Arbitration is round-robin.
//   Each requester hands over a 14-bit binary value with a valid/ready handshake. The block returns
//   four BCD digits, tagged with the requester ID, on a single valid/ready response port.
//   It sits between status/counter sources and the display drivers. It replaces per-source
//   combinational converters.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8; ID_W = $clog2(NUM_REQ) (localparam)
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   req_valid  in   NUM_REQ        per-requester valid
//   req_data   in   14*NUM_REQ     requester i value in [14*i+13:14*i]
//   req_ready  out  NUM_REQ        one-hot accept strobe; all zero when not accepting
//   rsp_valid  out  1              result available
//   rsp_ready  in   1              consumer accepts result
//   rsp_id     out  ID_W           index of requester that owns the result
//   rsp_bcd    out  16             {thousands,hundreds,tens,ones}
//   rsp_ovf    out  1              input exceeded 9999
//   busy       out  1              state != IDLE
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0,
//     rsp_bcd=0, rsp_ovf=0, busy=0, shift count=0. req_ready=0 while rst_n=0.
//   - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//     - IDLE: the grant g is the first index with req_valid high, searching cyclically from
//       rr_ptr. req_ready[g]=1 is combinational, in the same cycle, and is asserted only in IDLE.
//     - At that edge, the block captures the value and g, and sets rr_ptr=(g+1) mod NUM_REQ.
//       With no valid request, the block stays in IDLE and rr_ptr is unchanged.
//   - Capture, value <= 9999: load a 30-bit shift register {16'h0, value} and a count of 0,
//     then go to SHIFT.
//   - Capture, value > 9999: skip SHIFT and go straight to DONE with rsp_bcd=16'h9999 and
//     rsp_ovf=1. In this case rsp_valid is high in the cycle after the accept edge.
//   - SHIFT: on each edge, every BCD nibble >= 5 gets +3. The whole register then shifts left by 1.
//     - The count increments each edge.
//     - On the 14th shift edge the block goes to DONE. rsp_bcd is the upper 16 bits and rsp_ovf=0.
//     - rsp_valid is first high 14 cycles after the accept edge.
//   - DONE: rsp_valid=1. rsp_id, rsp_bcd and rsp_ovf are held stable until an edge with
//     rsp_ready=1. That edge clears rsp_valid and returns to IDLE.
//     - A new request is not accepted in that same cycle; there is one bubble.
//     - rsp_bcd and rsp_id keep their last values while rsp_valid=0.
//   - Throughput: 16 cycles per normal conversion and 2 per overflow conversion, with rsp_ready
//     tied high.
//   - Requesters hold valid and data stable until their req_ready strobe. The block neither
//     checks nor buffers a withdrawn request.
//   - A request from g that is still valid after service is re-arbitrated normally.
//     rr_ptr now points past g, so g has lowest priority.
//   - Reset mid-operation: the in-flight conversion is discarded, no response is produced and
//     rr_ptr returns to 0.
//   - Digit guarantee: every nibble of rsp_bcd is always in 0..9.
// TESTING
//   1. ch0 valid, data=1234 -> req_ready=4'b0001 for one cycle; 14 cycles later rsp_valid=1,
//      rsp_bcd=16'h1234, rsp_id=0, rsp_ovf=0.
//   2. Boundaries: data=0 -> 16'h0000; data=9999 -> 16'h9999, ovf=0;
//      data=10000 and data=16383 -> 16'h9999, ovf=1, rsp_valid one cycle after accept.
//   3. All four valid, held, rsp_ready=1 -> grant order 0,1,2,3,0; then only ch1 and ch3 valid
//      with rr_ptr=1 -> order 1,3,1.
//   4. Backpressure: rsp_ready=0 for 20 cycles in DONE with requests pending -> outputs stable,
//      req_ready=0; release -> one bubble, then the next grant.
//   5. rst_n pulsed low at shift count 7 -> all outputs reset immediately; no response appears;
//      first grant after release goes to the lowest valid index.
//   6. Random sweep of 2000 values, random valid/ready timing -> each response matches a
//      reference model (value, ID, ordering); every nibble <= 9.

Source files
------------

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler that shares one iterative shift-and-add-3 binary-to-BCD engine
// among NUM_REQ requesters; results return on a single tagged valid/ready port.
module bcd_convert_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [14*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_bcd,
    output logic                  rsp_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [29:0]     sreg_q, sreg_d, sreg_adj;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [13:0]     grant_data;

    function automatic logic [ID_W-1:0] wrap_add(logic [ID_W-1:0] base, int unsigned off);
        return ID_W'((32'(base) + off) % NUM_REQ);
    endfunction

    // Scan downwards so the last hit is the first valid index at or after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req_valid[wrap_add(rr_ptr_q, k - 1)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr_q, k - 1);
            end
        end
    end

    assign grant_data = req_data[14*32'(grant_idx) +: 14];

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sreg_adj = sreg_q;
        for (int i = 0; i < 4; i++) begin
            if (sreg_q[14+4*i +: 4] >= 4'd5) begin
                sreg_adj[14+4*i +: 4] = sreg_q[14+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_id_d = cur_id_q;
        rsp_id_d = rsp_id_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    rr_ptr_d = wrap_add(grant_idx, 1);
                    cur_id_d = grant_idx;
                    if (grant_data > 14'd9999) begin
                        // Saturate: four digits cannot hold the value.
                        rsp_id_d = grant_idx;
                        bcd_d    = 16'h9999;
                        ovf_d    = 1'b1;
                        state_d  = StDone;
                    end else begin
                        sreg_d  = {16'h0, grant_data};
                        cnt_d   = '0;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                sreg_d = sreg_adj << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    rsp_id_d = cur_id_q;
                    bcd_d    = sreg_d[29:14];
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            rsp_id_q <= '0;
            sreg_q   <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_id_q <= cur_id_d;
            rsp_id_q <= rsp_id_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = rsp_id_q;
    assign rsp_bcd   = bcd_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Bench for bcd_convert_scheduler: directed steps plus a random sweep checked against a
// decimal-arithmetic reference model with a round-robin grant predictor.
module tb_bcd_convert_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid;
    logic [55:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_bcd;
    logic        rsp_ovf;
    logic        busy;

    int total = 0;
    int bad = 0;

    bcd_convert_scheduler #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [13:0] rnd_val();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            case ($urandom_range(0, 3))
                0: return 14'd0;
                1: return 14'd9999;
                2: return 14'd10000;
                default: return 14'd16383;
            endcase
        end else if (r <= 2) begin
            return 14'($urandom_range(10000, 16383));
        end
        return 14'($urandom_range(0, 9999));
    endfunction

    // Reference model: round-robin pointer, outstanding flag and a queue of expected results.
    typedef struct {
        int          id;
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       m_e;
    int         m_rr, m_g, m_c, m_v, cyc, n_rsp;
    bit         m_busy, prev_valid;
    logic [3:0] m_exp_ready;
    logic [3:0] acc_seen;

    initial begin
        m_rr = 0; cyc = 0; n_rsp = 0; m_busy = 0; prev_valid = 0; acc_seen = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rr = 0;
            m_busy = 0;
            prev_valid = 0;
            acc_seen = '0;
        end else begin
            cyc++;
            m_g = -1;
            for (int k = 0; k < 4; k++) begin
                m_c = (m_rr + k) % 4;
                if (m_g < 0 && req_valid[m_c]) m_g = m_c;
            end
            m_exp_ready = (!m_busy && m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
            chk("req_ready", req_ready, m_exp_ready);
            if (m_exp_ready != 4'b0000) begin
                m_v = int'(req_data[14*m_g +: 14]);
                m_e.id = m_g;
                m_e.bcd = ref_bcd(m_v);
                m_e.ovf = (m_v > 9999);
                m_e.cyc = cyc;
                exp_q.push_back(m_e);
                m_rr = (m_g + 1) % 4;
                m_busy = 1;
            end
            acc_seen = req_ready & req_valid;
            if (rsp_valid && !prev_valid) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("rsp_latency", cyc - exp_q[0].cyc, exp_q[0].ovf ? 1 : 15);
            end
            if (rsp_valid && rsp_ready) begin
                for (int i = 0; i < 4; i++) chk("rsp_digit", rsp_bcd[4*i +: 4] <= 4'd9, 1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, m_e.id);
                    chk("rsp_bcd", rsp_bcd, m_e.bcd);
                    chk("rsp_ovf", rsp_ovf, m_e.ovf);
                end
                n_rsp++;
                m_busy = 0;
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", busy, 0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 in IDLE with rsp_ready high; returns at posedge+1 after the handshake.
    task automatic convert(input int ch, input logic [13:0] v, input int exp_lat,
                           input logic [15:0] eb, input logic eo);
        logic [3:0] oh;
        int lat;
        oh = 4'b0001 << ch;
        req_valid = oh;
        req_data[14*ch +: 14] = v;
        @(negedge clk);
        chk("conv_grant", req_ready, oh);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(lat);
        chk("conv_latency", lat, exp_lat);
        chk("conv_bcd", rsp_bcd, eb);
        chk("conv_id", rsp_id, ch);
        chk("conv_ovf", rsp_ovf, eo);
        @(posedge clk); #1;
    endtask

    int got[$];
    int exp4[5] = '{0, 1, 2, 3, 0};
    int exp3[3] = '{1, 3, 1};
    int lat, target, second;

    initial begin
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 req_valid = 4'hF;
        req_data = {14'd10, 14'd20, 14'd30, 14'd40};
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_bcd", rsp_bcd, 16'h0000);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0, 14'd1234, 14, 16'h1234, 1'b0);
        convert(0, 14'd0, 14, 16'h0000, 1'b0);
        convert(1, 14'd9999, 14, 16'h9999, 1'b0);
        convert(2, 14'd10000, 0, 16'h9999, 1'b1);
        convert(3, 14'd16383, 0, 16'h9999, 1'b1);
        wait_idle();

        // All four held valid: expect strict rotation starting at index 0.
        got.delete();
        req_data = {14'd4444, 14'd3333, 14'd2222, 14'd1111};
        req_valid = 4'hF;
        for (int k = 0; k < 200 && got.size() < 5; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) got.push_back(oh_idx(req_ready));
            @(posedge clk); #1;
        end
        req_valid = 4'b1010;
        chk("rr4_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("rr4_order", got[i], exp4[i]);
        got.delete();
        for (int k = 0; k < 200 && got.size() < 3; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) got.push_back(oh_idx(req_ready));
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("rr2_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("rr2_order", got[i], exp3[i]);
        wait_idle();

        // Backpressure with a pending request on ch0.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_data[28 +: 14] = 14'd4321;
        @(negedge clk);
        chk("bp_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_data[0 +: 14] = 14'd77;
        wait_rsp(lat);
        chk("bp_latency", lat, 14);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_bcd", rsp_bcd, 16'h4321);
            chk("bp_id", rsp_id, 2);
            chk("bp_ovf", rsp_ovf, 0);
            chk("bp_req_ready", req_ready, 4'b0000);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_no_grant", req_ready, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0001);
        chk("bp_valid_clear", rsp_valid, 0);
        chk("bp_id_keep", rsp_id, 2);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(lat);
        chk("bp2_latency", lat, 14);
        chk("bp2_bcd", rsp_bcd, 16'h0077);
        @(posedge clk); #1;

        // Reset mid-conversion at shift count 7.
        req_valid = 4'b0010;
        req_data[14 +: 14] = 14'd555;
        @(negedge clk);
        chk("mid_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b1001;
        req_data[0 +: 14] = 14'd100;
        req_data[42 +: 14] = 14'd300;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_bcd", rsp_bcd, 16'h0000);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_ovf", rsp_ovf, 0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = 4'b1000;
        second = 0;
        for (int k = 0; k < 60 && second == 0; k++) begin
            @(negedge clk);
            if (req_ready[3]) second = 1;
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("mid_second_grant", second, 1);
        wait_idle();

        // Random sweep against the reference model.
        target = n_rsp + 2000;
        for (int k = 0; k < 80000 && n_rsp < target; k++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (acc_seen[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[14*i +: 14] = rnd_val();
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[14*i +: 14] = rnd_val();
                end
            end
        end
        chk("sweep_done", n_rsp >= target, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 200 && (busy || exp_q.size() != 0); k++) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
